// File: rtl/pipe_stage_pr.sv
// rtl/pipe_stage_pr.sv - registered main/skid pipeline stage with flush and occupancy
// Optional bubble counter enabled by macro PIPE_BUBBLE_CNT_EN.
module pipe_stage_pr #(
  parameter int WIDTH  = 40,
  parameter int CTRL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ,
  output logic [15:0]      bubble_cnt
);

  // Shifting all-ones by WIDTH yields zero, so CTRL_W=0 needs no special case.
  localparam logic [WIDTH-1:0] CTRL_MASK = {WIDTH{1'b1}} >> (WIDTH - CTRL_W);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_valid_n, skid_valid_n;
  logic [WIDTH-1:0] main_data_n, skid_data_n;
  logic             xfer_in, xfer_out;

  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_data_n  = main_data;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
      main_data_n  = main_data & ~CTRL_MASK;
      skid_data_n  = skid_data & ~CTRL_MASK;
    end else if (xfer_out) begin
      // in_ready is low whenever skid holds data, so no input competes here.
      if (skid_valid) begin
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else if (xfer_in) begin
        main_data_n = in_data;
      end else begin
        main_valid_n = 1'b0;
      end
    end else if (xfer_in) begin
      if (!main_valid) begin
        main_data_n  = in_data;
        main_valid_n = 1'b1;
      end else begin
        skid_data_n  = in_data;
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
      occ        <= 2'd0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      in_ready   <= !skid_valid_n;
      occ        <= {1'b0, main_valid_n} + {1'b0, skid_valid_n};
    end
  end

`ifdef PIPE_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_cnt <= 16'd0;
    end else if (flush) begin
      bubble_cnt <= 16'd0;
    end else if (!main_valid && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`else
  assign bubble_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_pr.sv
// tb/tb_pipe_stage_pr.sv - queue-model self-checking bench for pipe_stage_pr
module tb_pipe_stage_pr;
  localparam int WIDTH  = 40;
  localparam int CTRL_W = 8;
  localparam logic [WIDTH-1:0] CMASK = {{(WIDTH-CTRL_W){1'b0}}, {CTRL_W{1'b1}}};

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occ;
  logic [15:0]      bubble_cnt;

  pipe_stage_pr #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: FIFO of accepted words, plus the last word shown on out_data.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] shown = '0;
  int bub = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic verify();
    int exp_bub;
`ifdef PIPE_BUBBLE_CNT_EN
    exp_bub = bub;
`else
    exp_bub = 0;
`endif
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_data, shown);
    check("in_ready", in_ready, q.size() < 2);
    check("occ", occ, q.size());
    check("bubble_cnt", bubble_cnt, exp_bub);
  endtask

  task automatic model_reset();
    q.delete();
    shown = '0;
    bub = 0;
  endtask

  task automatic cycle(input logic fl, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    int  sz;
    bit  tin, tout;
    flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    sz = q.size();
    if (fl) begin
      q.delete();
      shown = shown & ~CMASK;
      bub = 0;
    end else begin
      tin  = iv && sz < 2;
      tout = sz > 0 && ordy;
      if (sz == 0 && bub < 65535) bub++;
      if (tout) void'(q.pop_front());
      if (tin) q.push_back(d);
      if (q.size() > 0) shown = q[0];
    end
    #1 verify();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12 verify();
    @(negedge clk); rst = 1'b1;
    #1 check("in_ready_release", in_ready, 1);

    for (int i = 0; i < 5; i++) cycle(0, 0, '0, 0);
`ifdef PIPE_BUBBLE_CNT_EN
    check("bubble_idle5", bubble_cnt, 5);
`endif

    cycle(0, 1, 40'h12_3456_7801, 1);
    check("first_word", out_data, 40'h12_3456_7801);
    check("first_occ", occ, 1);
    cycle(0, 0, '0, 1);

    cycle(0, 1, 40'h1, 0);
    cycle(0, 1, 40'h2, 0);
    check("skid_occ2", occ, 2);
    check("skid_in_ready", in_ready, 0);
    check("skid_hold_a", out_data, 40'h1);
    cycle(0, 0, '0, 0);
    check("skid_hold_a2", out_data, 40'h1);
    cycle(0, 0, '0, 1);
    check("drain_b", out_data, 40'h2);
    check("ready_after_a", in_ready, 1);
    cycle(0, 0, '0, 1);

    cycle(0, 1, 40'hFF_FFFF_FFFF, 0);
    cycle(0, 1, 40'h33, 0);
    cycle(1, 1, 40'h77, 0);
    check("flush_occ", occ, 0);
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 40'hFF_FFFF_FF00);
    cycle(0, 0, '0, 1);

    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, WIDTH'(i), 1);
      check("stream_data", out_data, i);
      check("stream_occ", occ, 1);
    end
    cycle(0, 0, '0, 1);

    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(15) == 0, $urandom_range(3) != 0,
            {$urandom(), $urandom()}, $urandom_range(2) != 0);

    cycle(0, 1, 40'hA, 0);
    cycle(0, 1, 40'hB, 0);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", out_valid, 0);
    check("async_rst_occ", occ, 0);
    verify();
    @(negedge clk); rst = 1'b1;
    #1 check("rst_release_ready", in_ready, 1);
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(31) == 0, $urandom_range(1), {$urandom(), $urandom()}, $urandom_range(1));

`ifdef PIPE_BUBBLE_CNT_EN
    cycle(1, 0, '0, 0);
    check("bubble_flush", bubble_cnt, 0);
    for (int i = 0; i < 70000; i++) cycle(0, 0, '0, 0);
    check("bubble_sat", bubble_cnt, 16'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_pr.md
PIPE_STAGE_PR -- requirements
Module: pipe_stage_pr

Interface
REQ-001 SHALL have parameter WIDTH, default 40: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter CTRL_W, default 8: number of payload LSBs treated as control bits, legal range 0..WIDTH.
REQ-003 SHALL use one clock and asynchronous active-low reset: clk, rst (rst low = reset asserted).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_ready  output  1  stage can accept; driven directly from a register, with no combinational path from out_ready.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 out_data  output  WIDTH  payload; driven directly from a register.
REQ-013 occ  output  2  entries held (0..2).
REQ-014 bubble_cnt  output  16  cycles with out_valid low (see REQ-030).

Function
REQ-015 SHALL store entries in two registers, main (drives out_data) and skid, each with its own valid bit.
- Transfer in = in_valid & in_ready.
- Transfer out = out_valid & out_ready.
REQ-016 SHALL set in_ready = !skid_valid.
REQ-017 SHALL set out_valid = main_valid.
REQ-018 SHALL load in_data into main when transfer in occurs and (main empty or transfer out) and skid is empty. Latency is 1 cycle: out_valid rises on the edge after acceptance.
REQ-019 SHALL load in_data into skid when transfer in occurs, main is valid, and there is no transfer out.
REQ-020 SHALL move skid to main on transfer out when skid is valid, and clear skid_valid in that cycle. A new input is not accepted that cycle because in_ready is 0.
REQ-021 SHALL hold main and skid unchanged while out_ready=0, flush=0 and there is no transfer in; out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve order: entries leave in acceptance order, with no loss or duplication.
REQ-023 SHALL make occ equal main_valid + skid_valid, registered.
REQ-024 Flush SHALL take priority over every other event. On the edge where flush=1:
- clear main_valid and skid_valid;
- drive the CTRL_W LSBs of main and skid to 0;
- discard any concurrent transfer in, even though in_ready may read 1;
- ignore out_ready in that cycle; out_valid is still 1 during the flush cycle if main was valid.
REQ-025 SHALL leave the WIDTH-CTRL_W non-control bits unchanged on flush.
REQ-026 With occ=2 and simultaneous transfer out, SHALL end with occ=1 (skid moved to main).
REQ-027 With occ=1, transfer in and transfer out together, SHALL end with occ=1 and main = new data.
REQ-028 SHALL never exceed occ=2; in_ready=0 at occ=2.

Reset
REQ-029 On rst low, asynchronously:
- main_valid=0, skid_valid=0;
- out_data=0, skid data=0;
- occ=0, bubble_cnt=0;
- in_ready=1 throughout reset and on release.
A reset asserted mid-transfer SHALL discard all entries.

Configuration
REQ-030 With macro PIPE_BUBBLE_CNT_EN defined, bubble_cnt SHALL behave as follows:
- increment by 1 each cycle with out_valid=0;
- saturate at 16'hFFFF;
- clear to 0 synchronously on flush; the flush cycle itself is not counted.
REQ-031 Without PIPE_BUBBLE_CNT_EN, bubble_cnt SHALL be constant 0, the port SHALL remain present, and no counter flops SHALL be inferred.

Verification
REQ-032 Reset, then in_valid=1 with in_data=40'h12_3456_7801, out_ready=1 -> next cycle out_valid=1, out_data=40'h12_3456_7801, occ=1.
REQ-033 out_ready=0, send A=40'h1 then B=40'h2 -> occ=2, in_ready=0, out_data=A held; then out_ready=1 -> A, B delivered in consecutive cycles, and in_ready=1 one cycle after A leaves.
REQ-034 occ=2 holding 40'hFF_FFFF_FFFF, pulse flush with in_valid=1 -> next cycle occ=0, out_valid=0, out_data=40'hFF_FFFF_FF00 (CTRL_W=8), incoming word lost.
REQ-035 Continuous in_valid=1 and out_ready=1 for 100 words 0..99 -> output is 0..99 in order, one per cycle, occ stays 1.
REQ-036 PIPE_BUBBLE_CNT_EN defined, idle for 5 cycles after reset -> bubble_cnt=5; flush -> 0; force out_valid=0 for 70000 cycles -> 16'hFFFF.
REQ-037 Assert rst low mid-stream with occ=2 -> out_valid=0 and occ=0 immediately, without waiting for clk; after release, in_ready=1.
